// File: rtl/leaderboard_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : leaderboard_ctrl_if
// Brief   : Station-side submission bus for leaderboard_ctrl: requests with
//           score/id payload, and per-station ack with rank result.
// Rev     : 1.0  initial release
// ============================================================================
interface leaderboard_ctrl_if #(
    parameter int N_REQ   = 4,
    parameter int SCORE_W = 8,
    parameter int ID_W    = 3
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*SCORE_W-1:0] score_in;
    logic [N_REQ*ID_W-1:0]    id_in;
    logic [N_REQ-1:0]         ack;
    logic [1:0]               rank;
    logic                     busy;
    logic                     upd;

    modport master (output req, score_in, id_in, input  ack, rank, busy, upd);
    modport slave  (input  req, score_in, id_in, output ack, rank, busy, upd);
endinterface
`default_nettype wire

// File: rtl/leaderboard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : leaderboard_ctrl
// Brief   : Round-robin arbiter feeding a ranked top-3 score/id table.
//           Optional macro LEADERBOARD_TIE_NEWER_EN: newer equal score ranks
//           above the incumbent (default: incumbent keeps its place).
// Rev     : 1.0  initial release
// ============================================================================
module leaderboard_ctrl #(
    parameter int N_REQ   = 4,
    parameter int SCORE_W = 8,
    parameter int ID_W    = 3
) (
    input  wire                clk,
    input  wire                clr_n,
    leaderboard_ctrl_if.slave  bus,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [SCORE_W-1:0] score3,
    output logic [ID_W-1:0]    id1,
    output logic [ID_W-1:0]    id2,
    output logic [ID_W-1:0]    id3,
    output logic [2:0]         vld
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_winner;
    logic [SCORE_W-1:0] r_score;
    logic [ID_W-1:0]    r_id;
    logic [1:0]         r_rank;

    logic               w_any;
    logic               w_hit_hi;
    logic [PTR_W-1:0]   w_gnt_hi;
    logic [PTR_W-1:0]   w_gnt_lo;
    logic [PTR_W-1:0]   w_gnt;
    logic [SCORE_W-1:0] w_gnt_score;
    logic [ID_W-1:0]    w_gnt_id;
    logic [2:0]         w_beats;
    logic [1:0]         w_rank;
    logic [N_REQ-1:0]   w_ack_vec;
    logic [PTR_W-1:0]   w_next_ptr;

    assign w_any = |bus.req;

    // Lowest request at or above rr_ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_hit_hi = 1'b0;
        w_gnt_hi = '0;
        w_gnt_lo = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_gnt_lo = PTR_W'(i);
            end
            if (bus.req[i] && (PTR_W'(i) >= r_rr_ptr)) begin
                w_hit_hi = 1'b1;
                w_gnt_hi = PTR_W'(i);
            end
        end
        w_gnt = w_hit_hi ? w_gnt_hi : w_gnt_lo;
    end

    always_comb begin
        w_gnt_score = '0;
        w_gnt_id    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt == PTR_W'(i)) begin
                w_gnt_score = bus.score_in[i*SCORE_W +: SCORE_W];
                w_gnt_id    = bus.id_in[i*ID_W +: ID_W];
            end
        end
    end

    // An empty slot always loses to the new entry, whatever its score.
`ifdef LEADERBOARD_TIE_NEWER_EN
    assign w_beats = {r_score >= score3, r_score >= score2, r_score >= score1} | ~vld;
`else
    assign w_beats = {r_score > score3, r_score > score2, r_score > score1} | ~vld;
`endif

    assign w_rank = w_beats[0] ? 2'd1 :
                    w_beats[1] ? 2'd2 :
                    w_beats[2] ? 2'd3 : 2'd0;

    always_comb begin
        w_ack_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_ack_vec[i] = (r_winner == PTR_W'(i));
        end
    end

    assign w_next_ptr = (r_winner == PTR_W'(N_REQ - 1)) ? '0 : r_winner + PTR_W'(1);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_score  <= '0;
            r_id     <= '0;
            r_rank   <= 2'd0;
            score1   <= '0;
            score2   <= '0;
            score3   <= '0;
            id1      <= '0;
            id2      <= '0;
            id3      <= '0;
            vld      <= 3'b000;
            bus.ack  <= '0;
            bus.rank <= 2'd0;
            bus.busy <= 1'b0;
            bus.upd  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_winner <= w_gnt;
                        r_score  <= w_gnt_score;
                        r_id     <= w_gnt_id;
                        bus.busy <= 1'b1;
                        r_state  <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_rank  <= w_rank;
                    r_state <= S_WR;
                end
                S_WR: begin
                    case (r_rank)
                        2'd1: begin
                            score3 <= score2;   id3 <= id2;   vld[2] <= vld[1];
                            score2 <= score1;   id2 <= id1;   vld[1] <= vld[0];
                            score1 <= r_score;  id1 <= r_id;  vld[0] <= 1'b1;
                        end
                        2'd2: begin
                            score3 <= score2;   id3 <= id2;   vld[2] <= vld[1];
                            score2 <= r_score;  id2 <= r_id;  vld[1] <= 1'b1;
                        end
                        2'd3: begin
                            score3 <= r_score;  id3 <= r_id;  vld[2] <= 1'b1;
                        end
                        default: ;
                    endcase
                    r_rr_ptr <= w_next_ptr;
                    bus.ack  <= w_ack_vec;
                    bus.rank <= r_rank;
                    bus.upd  <= (r_rank != 2'd0);
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    bus.ack  <= '0;
                    bus.rank <= 2'd0;
                    bus.upd  <= 1'b0;
                    bus.busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_leaderboard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_leaderboard_ctrl
// Brief   : Self-checking bench: directed vector table, multi-cycle corner
//           sequences and randomized submissions against a ranked-list model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_leaderboard_ctrl;
    localparam int N_REQ   = 4;
    localparam int SCORE_W = 8;
    localparam int ID_W    = 3;
`ifdef LEADERBOARD_TIE_NEWER_EN
    localparam int TIE_RANK = 2;
`else
    localparam int TIE_RANK = 3;
`endif

    logic               clk = 1'b0;
    logic               clr_n = 1'b0;
    logic [SCORE_W-1:0] score1, score2, score3;
    logic [ID_W-1:0]    id1, id2, id3;
    logic [2:0]         vld;

    leaderboard_ctrl_if #(.N_REQ(N_REQ), .SCORE_W(SCORE_W), .ID_W(ID_W)) bus ();

    leaderboard_ctrl #(.N_REQ(N_REQ), .SCORE_W(SCORE_W), .ID_W(ID_W)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .bus    (bus),
        .score1 (score1),
        .score2 (score2),
        .score3 (score3),
        .id1    (id1),
        .id2    (id2),
        .id3    (id3),
        .vld    (vld)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {int sc; int id;} entry_t;
    entry_t model_q[$];

    typedef struct {bit rst; int st; int sc; int id; int rank;} vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Ranked list, best first; equal scores stay in arrival order unless newer wins ties.
    function automatic int model_rank(input int sc);
        int above = 0;
        foreach (model_q[k]) begin
`ifdef LEADERBOARD_TIE_NEWER_EN
            if (model_q[k].sc > sc) above++;
`else
            if (model_q[k].sc >= sc) above++;
`endif
        end
        return (above < 3) ? above + 1 : 0;
    endfunction

    task automatic model_insert(input int rk, input int sc, input int id);
        entry_t e;
        if (rk != 0) begin
            e.sc = sc;
            e.id = id;
            model_q.insert(rk - 1, e);
            if (model_q.size() > 3) void'(model_q.pop_back());
        end
    endtask

    task automatic check_table(input string tag);
        logic [SCORE_W-1:0] es [3];
        logic [ID_W-1:0]    ei [3];
        logic [2:0]         ev;
        ev = 3'b000;
        for (int k = 0; k < 3; k++) begin
            es[k] = '0;
            ei[k] = '0;
            if (k < model_q.size()) begin
                es[k] = SCORE_W'(model_q[k].sc);
                ei[k] = ID_W'(model_q[k].id);
                ev[k] = 1'b1;
            end
        end
        check({tag, " score1"}, score1, es[0]);
        check({tag, " score2"}, score2, es[1]);
        check({tag, " score3"}, score3, es[2]);
        check({tag, " id1"}, id1, ei[0]);
        check({tag, " id2"}, id2, ei[1]);
        check({tag, " id3"}, id3, ei[2]);
        check({tag, " vld"}, vld, ev);
    endtask

    task automatic do_reset();
        bus.req      = '0;
        bus.score_in = '0;
        bus.id_in    = '0;
        clr_n        = 1'b0;
        model_q.delete();
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
    endtask

    // One full submission from an idle controller; exp_rank < 0 means model only.
    task automatic submit(input int st, input int sc, input int id, input int exp_rank,
                          input string tag);
        int n;
        int mr;
        @(posedge clk);
        #1;
        bus.req[st] = 1'b1;
        bus.score_in[st*SCORE_W +: SCORE_W] = SCORE_W'(sc);
        bus.id_in[st*ID_W +: ID_W] = ID_W'(id);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                bus.score_in[st*SCORE_W +: SCORE_W] = ~SCORE_W'(sc);
                bus.id_in[st*ID_W +: ID_W] = ~ID_W'(id);
            end
        end while (bus.ack == '0 && n < 10);
        mr = model_rank(sc);
        check({tag, " latency"}, n, 3);
        check({tag, " ack"}, bus.ack, N_REQ'(1) << st);
        check({tag, " busy_in_done"}, bus.busy, 1'b1);
        if (exp_rank >= 0) check({tag, " rank_expected"}, bus.rank, exp_rank);
        check({tag, " rank_model"}, bus.rank, mr);
        check({tag, " upd"}, bus.upd, (mr != 0));
        bus.req[st] = 1'b0;
        model_insert(mr, sc, id);
        @(posedge clk);
        #1;
        check({tag, " ack_clear"}, bus.ack, 0);
        check({tag, " idle_busy"}, bus.busy, 0);
        check({tag, " upd_clear"}, bus.upd, 0);
        check_table(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int st;
        int sc;
        int id;

        vecs[0] = '{1'b1, 0, 50, 2, 1};
        vecs[1] = '{1'b0, 1, 30, 3, 2};
        vecs[2] = '{1'b0, 2, 40, 4, 2};
        vecs[3] = '{1'b0, 3, 10, 1, 0};
        vecs[4] = '{1'b0, 1, 60, 5, 1};
        vecs[5] = '{1'b1, 0, 50, 1, 1};
        vecs[6] = '{1'b0, 1, 40, 2, 2};
        vecs[7] = '{1'b0, 2, 30, 3, 3};
        vecs[8] = '{1'b0, 3, 40, 6, TIE_RANK};

        do_reset();
        #1;
        check("reset busy", bus.busy, 0);
        check("reset ack", bus.ack, 0);
        check("reset rank", bus.rank, 0);
        check("reset upd", bus.upd, 0);
        check_table("reset");

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            submit(vecs[i].st, vecs[i].sc, vecs[i].id, vecs[i].rank, $sformatf("vec%0d", i));
            if (i == 0) begin
                check("vec0 score1_50", score1, 50);
                check("vec0 id1_2", id1, 2);
                check("vec0 vld_001", vld, 3'b001);
            end
            if (i == 4) begin
                check("vec4 ids_follow", {id1, id2, id3}, {3'd5, 3'd2, 3'd4});
                check("vec4 scores", {score1, score2, score3}, {8'd60, 8'd50, 8'd40});
            end
        end

        // All stations hold req from reset: grants rotate 0,1,2,3 then wrap to 0.
        clr_n = 1'b0;
        model_q.delete();
        for (int i = 0; i < N_REQ; i++) begin
            bus.score_in[i*SCORE_W +: SCORE_W] = SCORE_W'(10 * (i + 1));
            bus.id_in[i*ID_W +: ID_W] = ID_W'(i + 1);
        end
        bus.req = '1;
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (bus.ack == '0 && n < 12);
            check($sformatf("rr%0d gap", k), n, (k == 0) ? 3 : 4);
            check($sformatf("rr%0d ack", k), bus.ack, N_REQ'(1) << (k % N_REQ));
            check($sformatf("rr%0d rank", k), bus.rank, model_rank(10 * ((k % N_REQ) + 1)));
            model_insert(model_rank(10 * ((k % N_REQ) + 1)), 10 * ((k % N_REQ) + 1),
                         (k % N_REQ) + 1);
        end
        bus.req = '0;
        @(posedge clk);
        #1;
        check_table("rr");

        // Reset while the controller is comparing abandons the transaction.
        do_reset();
        @(posedge clk);
        #1;
        bus.req[2] = 1'b1;
        bus.score_in[2*SCORE_W +: SCORE_W] = 8'd70;
        bus.id_in[2*ID_W +: ID_W] = 3'd6;
        @(posedge clk);
        #1;
        check("midrst busy_before", bus.busy, 1);
        clr_n = 1'b0;
        #1;
        check("midrst busy", bus.busy, 0);
        check("midrst ack", bus.ack, 0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst no_ack", bus.ack, 0);
        bus.req = '0;
        model_q.delete();
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst upd", bus.upd, 0);
        check_table("midrst");
        submit(2, 70, 6, 1, "midrst resub");

        // Randomized submissions; narrow score range forces frequent ties.
        do_reset();
        for (int r = 0; r < 40; r++) begin
            st = int'($urandom_range(0, N_REQ - 1));
            sc = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) sc = int'($urandom_range(0, 255));
            id = int'($urandom_range(0, 7));
            submit(st, sc, id, -1, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
